// File: rtl/led_matrix_status_scanner_pkg.sv
// Shared constants for the status LED matrix scanner: FSM encodings and default matrix geometry.
// The status decoders import the same geometry so their image_in packing stays consistent.
package led_matrix_status_scanner_pkg;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_SCAN  = 2'd1;
    localparam logic [1:0] ST_BLANK = 2'd2;

    localparam int DEF_NUM_COLS = 5;
    localparam int DEF_NUM_ROWS = 7;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/led_matrix_frame_buffer.sv
// Double buffer for the LED matrix image: shadow accepts a new image over valid/ready,
// active is what the scanner displays and is replaced from shadow only when the scanner asks.
module led_matrix_frame_buffer
    import led_matrix_status_scanner_pkg::*;
#(
    parameter int IMG_W = DEF_NUM_COLS * DEF_NUM_ROWS
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clear,
    input  logic [IMG_W-1:0] image_in,
    input  logic             image_valid,
    input  logic             swap,
    output logic             image_ready,
    output logic             shadow_full,
    output logic [IMG_W-1:0] active_nxt
);

    logic [IMG_W-1:0] shadow_q, shadow_d;
    logic [IMG_W-1:0] active_q, active_d;
    logic             shadow_full_q, shadow_full_d;
    logic             ready_q, ready_d;
    logic             xfer;

    // Swap only happens while shadow is full, so ready is low and no transfer can collide with it.
    always_comb begin
        xfer          = image_valid & ready_q & ~clear;
        shadow_d      = xfer ? image_in : shadow_q;
        active_d      = swap ? shadow_q : active_q;
        shadow_full_d = shadow_full_q;
        if (clear || swap) begin
            shadow_full_d = 1'b0;
        end else if (xfer) begin
            shadow_full_d = 1'b1;
        end
        ready_d = ~shadow_full_d;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shadow_q      <= '0;
            active_q      <= '0;
            shadow_full_q <= 1'b0;
            ready_q       <= 1'b1;
        end else begin
            shadow_q      <= shadow_d;
            active_q      <= active_d;
            shadow_full_q <= shadow_full_d;
            ready_q       <= ready_d;
        end
    end

    assign image_ready = ready_q;
    assign shadow_full = shadow_full_q;
    assign active_nxt  = active_d;

endmodule

// File: rtl/led_matrix_status_scanner.sv
// Column-multiplexed status LED matrix driver with blank gaps, frame-boundary image swap and blink.
// state | meaning
// IDLE  | nothing lit, waiting for the first image in the shadow buffer
// SCAN  | column col_idx lit with its row pattern for SCAN_CYCLES clocks
// BLANK | all columns off for BLANK_CYCLES clocks before the next column
module led_matrix_status_scanner
    import led_matrix_status_scanner_pkg::*;
#(
    parameter int NUM_COLS     = DEF_NUM_COLS,
    parameter int NUM_ROWS     = DEF_NUM_ROWS,
    parameter int SCAN_CYCLES  = 1000,
    parameter int BLANK_CYCLES = 20,
    parameter int BLINK_FRAMES = 50,
    parameter int COL_ACT_LOW  = 1
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         clear,
    input  logic [NUM_COLS*NUM_ROWS-1:0] image_in,
    input  logic                         image_valid,
    output logic                         image_ready,
    input  logic                         blink_en,
    output logic [NUM_COLS-1:0]          col_sel,
    output logic [NUM_ROWS-1:0]          row_data,
    output logic                         frame_done
);

    localparam int IMG_W = NUM_COLS * NUM_ROWS;
    localparam int CNT_W = $clog2(max_int(SCAN_CYCLES, BLANK_CYCLES) + 1);
    localparam int FR_W  = $clog2(BLINK_FRAMES + 1);
    localparam int COL_W = (NUM_COLS > 1) ? $clog2(NUM_COLS) : 1;

    localparam logic [CNT_W-1:0]    SCAN_LD  = CNT_W'(SCAN_CYCLES - 1);
    localparam logic [CNT_W-1:0]    BLANK_LD = CNT_W'((BLANK_CYCLES > 0) ? BLANK_CYCLES - 1 : 0);
    localparam logic [FR_W-1:0]     FR_LAST  = FR_W'(BLINK_FRAMES - 1);
    localparam logic [COL_W-1:0]    COL_LAST = COL_W'(NUM_COLS - 1);
    localparam logic [NUM_COLS-1:0] COL_OFF  = (COL_ACT_LOW != 0) ? {NUM_COLS{1'b1}} : '0;

    logic [1:0]          state_q, state_d;
    logic [COL_W-1:0]    col_idx_q, col_idx_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [FR_W-1:0]     frame_cnt_q, frame_cnt_d;
    logic                phase_q, phase_d;
    logic [NUM_COLS-1:0] col_sel_q, col_sel_d;
    logic [NUM_ROWS-1:0] row_data_q, row_data_d;
    logic                frame_done_q, frame_done_d;

    logic             swap, col_start, wrap, advance, shadow_full;
    logic [IMG_W-1:0] active_nxt;

    led_matrix_frame_buffer #(
        .IMG_W(IMG_W)
    ) u_frame_buffer (
        .clk        (clk),
        .rst_n      (rst_n),
        .clear      (clear),
        .image_in   (image_in),
        .image_valid(image_valid),
        .swap       (swap),
        .image_ready(image_ready),
        .shadow_full(shadow_full),
        .active_nxt (active_nxt)
    );

    always_comb begin
        state_d      = state_q;
        col_idx_d    = col_idx_q;
        cnt_d        = cnt_q;
        frame_cnt_d  = frame_cnt_q;
        phase_d      = phase_q;
        swap         = 1'b0;
        col_start    = 1'b0;
        wrap         = 1'b0;
        advance      = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (shadow_full) begin
                    state_d   = ST_SCAN;
                    col_idx_d = '0;
                    cnt_d     = SCAN_LD;
                    col_start = 1'b1;
                    swap      = 1'b1;
                end
            end
            ST_SCAN: begin
                if (cnt_q == '0) begin
                    if (BLANK_CYCLES == 0) begin
                        advance = 1'b1;
                    end else begin
                        state_d = ST_BLANK;
                        cnt_d   = BLANK_LD;
                    end
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            ST_BLANK: begin
                if (cnt_q == '0) begin
                    advance = 1'b1;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        if (advance) begin
            state_d   = ST_SCAN;
            cnt_d     = SCAN_LD;
            col_start = 1'b1;
            if (col_idx_q == COL_LAST) begin
                col_idx_d = '0;
                wrap      = 1'b1;
                swap      = shadow_full;
            end else begin
                col_idx_d = col_idx_q + 1'b1;
            end
        end

        if (!blink_en) begin
            frame_cnt_d = '0;
            phase_d     = 1'b1;
        end else if (wrap) begin
            if (frame_cnt_q == FR_LAST) begin
                frame_cnt_d = '0;
                phase_d     = ~phase_q;
            end else begin
                frame_cnt_d = frame_cnt_q + 1'b1;
            end
        end

        frame_done_d = wrap;

        if (clear) begin
            state_d      = ST_IDLE;
            col_idx_d    = '0;
            cnt_d        = '0;
            frame_cnt_d  = '0;
            phase_d      = 1'b1;
            swap         = 1'b0;
            col_start    = 1'b0;
            frame_done_d = 1'b0;
        end

        // Row pattern is latched at column start so blink changes never cut a column short.
        col_sel_d  = COL_OFF;
        row_data_d = '0;
        if (state_d == ST_SCAN) begin
            col_sel_d = COL_OFF ^ (NUM_COLS'(1) << col_idx_d);
            if (col_start) begin
                row_data_d = phase_d ? active_nxt[int'(col_idx_d)*NUM_ROWS +: NUM_ROWS] : '0;
            end else begin
                row_data_d = row_data_q;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            col_idx_q    <= '0;
            cnt_q        <= '0;
            frame_cnt_q  <= '0;
            phase_q      <= 1'b1;
            col_sel_q    <= COL_OFF;
            row_data_q   <= '0;
            frame_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            col_idx_q    <= col_idx_d;
            cnt_q        <= cnt_d;
            frame_cnt_q  <= frame_cnt_d;
            phase_q      <= phase_d;
            col_sel_q    <= col_sel_d;
            row_data_q   <= row_data_d;
            frame_done_q <= frame_done_d;
        end
    end

    assign col_sel    = col_sel_q;
    assign row_data   = row_data_q;
    assign frame_done = frame_done_q;

endmodule
